// File: rtl/tsp_pkg.sv
// Shared TSP types and sizes, used by the solver and the tour evaluator.
package tsp_pkg;
    localparam int N_CITIES = 64;
    localparam int COORD_W  = 32;
    localparam int IDX_W    = $clog2(N_CITIES);
    localparam int COST_W   = COORD_W + 1 + IDX_W;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   dist_t;
    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [COST_W-1:0]  cost_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} eval_state_t;
endpackage

// File: rtl/tsp_manhattan.sv
// Combinational Manhattan distance between two points, full width with no truncation.
module tsp_manhattan
    import tsp_pkg::*;
(
    input  coord_t ax,
    input  coord_t ay,
    input  coord_t bx,
    input  coord_t by,
    output dist_t  d
);
    coord_t dx;
    coord_t dy;

    assign dx = (ax >= bx) ? ax - bx : bx - ax;
    assign dy = (ay >= by) ? ay - by : by - ay;
    assign d  = {1'b0, dx} + {1'b0, dy};
endmodule

// File: rtl/tsp_tour_eval.sv
// Tour scorer: walks the closed tour one edge per cycle, sums Manhattan length,
// tracks the longest edge and checks that the path is a permutation.
module tsp_tour_eval
    import tsp_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  coord_t xs   [N_CITIES],
    input  coord_t ys   [N_CITIES],
    input  coord_t path [N_CITIES],
    output logic   busy,
    output logic   done,
    output logic   valid,
    output cost_t  cost,
    output dist_t  max_edge,
    output idx_t   bad_index
);
    eval_state_t           state_q, state_d;
    idx_t                  k;
    idx_t                  k_next;
    logic [N_CITIES-1:0]   visited;

    coord_t a_raw, b_raw;
    idx_t   a_idx, b_idx;
    logic   a_ok, b_ok;
    logic   entry_bad;
    dist_t  d_raw, d_edge;

    // k wraps naturally because N_CITIES is a power of two.
    assign k_next = k + IDX_W'(1);
    assign a_raw  = path[k];
    assign b_raw  = path[k_next];
    assign a_ok   = a_raw < COORD_W'(N_CITIES);
    assign b_ok   = b_raw < COORD_W'(N_CITIES);
    assign a_idx  = a_raw[IDX_W-1:0];
    assign b_idx  = b_raw[IDX_W-1:0];

    tsp_manhattan u_dist (
        .ax (xs[a_idx]),
        .ay (ys[a_idx]),
        .bx (xs[b_idx]),
        .by (ys[b_idx]),
        .d  (d_raw)
    );

    // An edge touching an out-of-range city scores zero rather than aliasing a table entry.
    assign d_edge    = (a_ok && b_ok) ? d_raw : '0;
    assign entry_bad = !a_ok || visited[a_idx];

    // NOTE: every output and next-state signal gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN: begin
                busy = 1'b1;
                if (k == idx_t'(N_CITIES - 1)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            k         <= '0;
            visited   <= '0;
            valid     <= 1'b0;
            cost      <= '0;
            max_edge  <= '0;
            bad_index <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (start) begin
                    k         <= '0;
                    visited   <= '0;
                    valid     <= 1'b1;
                    cost      <= '0;
                    max_edge  <= '0;
                    bad_index <= '0;
                end
                RUN: begin
                    k    <= k_next;
                    cost <= cost + COST_W'(d_edge);
                    if (d_edge > max_edge) max_edge <= d_edge;
                    if (entry_bad) begin
                        // Only the first illegal position is reported.
                        if (valid) begin
                            valid     <= 1'b0;
                            bad_index <= k;
                        end
                    end else begin
                        visited[a_idx] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tsp_tour_eval.sv
// Self-checking bench for tsp_tour_eval: directed tours plus random tours scored by a loop-based model.
module tb_tsp_tour_eval;
    import tsp_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    logic   start;
    coord_t xs   [N_CITIES];
    coord_t ys   [N_CITIES];
    coord_t path [N_CITIES];
    logic   busy, done, valid;
    cost_t  cost;
    dist_t  max_edge;
    idx_t   bad_index;

    int total = 0;
    int bad   = 0;

    longint unsigned exp_cost, exp_max;
    bit              exp_valid;
    int              exp_bad;

    tsp_tour_eval dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .xs        (xs),
        .ys        (ys),
        .path      (path),
        .busy      (busy),
        .done      (done),
        .valid     (valid),
        .cost      (cost),
        .max_edge  (max_edge),
        .bad_index (bad_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned absdiff(input longint unsigned a, input longint unsigned b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Reference score straight from the tour rules.
    task automatic model();
        bit seen [N_CITIES];
        longint unsigned a, b, d;
        foreach (seen[i]) seen[i] = 1'b0;
        exp_cost = 0; exp_max = 0; exp_valid = 1'b1; exp_bad = 0;
        for (int i = 0; i < N_CITIES; i++) begin
            a = path[i];
            b = path[(i + 1) % N_CITIES];
            if (a < N_CITIES && !seen[int'(a)]) seen[int'(a)] = 1'b1;
            else if (exp_valid) begin
                exp_valid = 1'b0;
                exp_bad   = i;
            end
            d = 0;
            if (a < N_CITIES && b < N_CITIES)
                d = absdiff(xs[int'(a)], xs[int'(b)]) + absdiff(ys[int'(a)], ys[int'(b)]);
            exp_cost += d;
            if (d > exp_max) exp_max = d;
        end
    endtask

    task automatic check_results(input string tag);
        check({tag, "_cost"},      64'(cost),      exp_cost);
        check({tag, "_max_edge"},  64'(max_edge),  exp_max);
        check({tag, "_valid"},     64'(valid),     64'(exp_valid));
        check({tag, "_bad_index"}, 64'(bad_index), 64'(exp_bad));
    endtask

    // Launch one evaluation from IDLE; optionally poke start mid-run to show it is ignored.
    task automatic run_eval(input string tag, input bit poke);
        int cycles   = 0;
        int busy_cnt = 0;
        bit got      = 1'b0;
        model();
        start = 1'b1;
        while (cycles < N_CITIES + 20 && !got) begin
            @(negedge clk);
            cycles++;
            start = poke && (cycles == 30 || cycles == N_CITIES + 1);
            if (busy) busy_cnt++;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 64'(got),          64'd1);
        check({tag, "_latency"},   64'(cycles - 1),   64'(N_CITIES));
        check({tag, "_busy_cyc"},  64'(busy_cnt),     64'(N_CITIES));
        check_results(tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_cost_hold"},  64'(cost), exp_cost);
    endtask

    task automatic identity_tables();
        for (int i = 0; i < N_CITIES; i++) begin
            xs[i] = coord_t'(i); ys[i] = '0; path[i] = coord_t'(i);
        end
    endtask

    initial begin
        int done_cnt, last_done, gap_ok, cyc;
        rst = 1'b1; start = 1'b0;
        identity_tables();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy",  64'(busy),      64'd0);
        check("reset_done",  64'(done),      64'd0);
        check("reset_valid", 64'(valid),     64'd0);
        check("reset_cost",  64'(cost),      64'd0);
        check("reset_max",   64'(max_edge),  64'd0);
        check("reset_bad",   64'(bad_index), 64'd0);

        // Identity tour on a line; start is poked during RUN and DONE.
        run_eval("identity", 1'b1);
        check("identity_cost_const", 64'(cost), 64'd126);

        path[10] = 3;
        run_eval("dup10", 1'b0);
        check("dup10_bad_const", 64'(bad_index), 64'd10);

        identity_tables();
        path[5] = 64;
        run_eval("oob5", 1'b0);
        check("oob5_cost_const", 64'(cost), 64'd124);

        identity_tables();
        for (int i = 0; i < N_CITIES; i++) begin
            xs[i] = (i % 2 == 0) ? '0 : '1;
            ys[i] = (i % 2 == 0) ? '1 : '0;
        end
        run_eval("extreme", 1'b0);
        check("extreme_max_const", 64'(max_edge), 64'h1_FFFF_FFFE);

        // Reset in the middle of a run.
        identity_tables();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy",  64'(busy),  64'd0);
        check("midrst_cost",  64'(cost),  64'd0);
        check("midrst_valid", 64'(valid), 64'd0);
        done_cnt = 0;
        repeat (N_CITIES + 4) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("midrst_no_done", 64'(done_cnt), 64'd0);
        run_eval("after_rst", 1'b0);

        // Held-high start gives back-to-back evaluations.
        model();
        start = 1'b1; done_cnt = 0; last_done = -1; gap_ok = 1;
        for (cyc = 1; cyc <= 3 * (N_CITIES + 2); cyc++) begin
            @(negedge clk);
            if (done) begin
                if (last_done >= 0 && cyc - last_done != N_CITIES + 2) gap_ok = 0;
                if (last_done < 0) check("held_first_lat", 64'(cyc - 1), 64'(N_CITIES));
                last_done = cyc;
                done_cnt++;
                check_results("held");
            end
        end
        start = 1'b0;
        repeat (N_CITIES + 4) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("held_done_count", 64'(done_cnt), 64'd3);
        check("held_spacing",    64'(gap_ok),   64'd1);

        // Random tables and tours with occasional corruption.
        for (int t = 0; t < 6; t++) begin
            int p, q, tmp;
            for (int i = 0; i < N_CITIES; i++) begin
                xs[i] = $urandom; ys[i] = $urandom; path[i] = coord_t'(i);
            end
            for (int i = N_CITIES - 1; i > 0; i--) begin
                q = int'($urandom_range(i, 0));
                tmp = int'(path[i]); path[i] = path[q]; path[q] = coord_t'(tmp);
            end
            case (t % 3)
                1: begin
                    p = int'($urandom_range(N_CITIES - 1, 1));
                    q = int'($urandom_range(p - 1, 0));
                    path[p] = path[q];
                end
                2: path[$urandom_range(N_CITIES - 1, 0)] = coord_t'(N_CITIES) + $urandom_range(5000, 0);
                default: ;
            endcase
            run_eval($sformatf("rand%0d", t), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
